twofish_arbiter: RTL and testbench
==================================

# twofish_arbiter

Round-robin arbiter and sequencer that shares one `twofish` core between two independent requesters. It latches the winner's key, block and direction, then drives the core through its reset-start/`end_signal` protocol. It returns the result with a one-cycle done pulse and guards each run with a timeout. It sits between the autotest or application logic and the single `twofish` instance.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum RUN cycles before a job is aborted; counter width is $clog2(TIMEOUT_CYCLES+1).
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_i`  in  2  request per requester (bit k = requester k).
- `enc_dec_i`  in  2  direction per requester, passed unchanged to the core.
- `key0_i`, `key1_i`  in  128  key per requester.
- `block0_i`, `block1_i`  in  128  input block per requester.
- `done_o`  out  2  one-cycle completion pulse; bit k addresses requester k.
- `err_o`  out  1  one-cycle pulse, coincident with `done_o`, set when the job timed out.
- `block_o`  out  128  result of the last completed job; held until the next completion.
- `busy_o`  out  1  high in every state except IDLE.
- `core_rst_o`  out  1  drives core `rst`; high holds the core idle.
- `core_enc_dec_o`  out  1  latched direction.
- `core_key_o`  out  128  latched key.
- `core_block_o`  out  128  latched input block.
- `core_block_i`  in  128  core `text_output`.
- `core_end_i`  in  1  core `end_signal`; stays high until the core is reset.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: `core_rst_o`=1.
  - If no bit of `req_i` is set, stay in IDLE.
  - If one bit is set, grant it.
  - If both bits are set, grant the requester opposite to `last_grant`.
  - On a grant, latch the granted enc_dec/key/block into the core_* registers, store the grant index in `grant` and `last_grant`, and go to LOAD.
- LOAD: `core_rst_o`=1 for exactly one cycle, so the core sees stable operands while in reset. Clear the timeout counter. Go to RUN.
- RUN: `core_rst_o`=0.
  - Each cycle, if `core_end_i`=1: capture `core_block_i` into `block_o`, clear the error flag, go to DONE.
  - Otherwise, if the counter equals TIMEOUT_CYCLES-1: set the error flag, leave `block_o` unchanged, go to DONE.
  - Otherwise, increment the counter.
- DONE: `core_rst_o`=1. Assert `done_o[grant]`=1, and `err_o`=error flag. Go to IDLE.
- Requester rules:
  - Hold `req_i[k]` with stable operands until `done_o[k]` is seen.
  - Drop `req_i[k]` in the cycle after `done_o[k]`.
  - `req_i[k]` still high in IDLE is treated as a new job.
- Operands are latched only in IDLE. Input changes after the grant do not affect a running job.
- `core_end_i` is ignored in IDLE, LOAD and DONE.
- `req_i` is ignored outside IDLE. A request arriving mid-job waits and is not lost.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1.

## Timing
- Reset values:
  - state IDLE, `core_rst_o`=1, `done_o`=0, `err_o`=0, `busy_o`=0.
  - `block_o`=0, core_* data and enc_dec=0, `last_grant`=1 (requester 0 wins the first tie), counter=0.
- Request to core start: `req_i` high at edge t (IDLE) → LOAD during cycle t+1 → `core_rst_o` falls for cycle t+2.
- Completion: `core_end_i` high in RUN cycle e → `block_o` valid and `done_o` pulse in cycle e+1 → IDLE in cycle e+2.
- Back-to-back jobs: the earliest next grant is evaluated in IDLE cycle e+2, so the IDLE-to-IDLE overhead is 3 cycles plus core latency.
- Timeout: with no `core_end_i`, DONE occurs exactly TIMEOUT_CYCLES+2 cycles after the grant edge, with `err_o`=1.
- `rst` mid-job: on the next edge, return to reset values immediately. No done pulse is issued and the core is held in reset.

## Test plan
- Single job: requester 0, key=0, block=0, enc_dec=encrypt → `done_o`=2'b01 with `block_o`=0x9F589F5CF6122C32B6BFEC2F2AE8C35A and `err_o`=0.
- Decrypt round trip: requester 1 submits that ciphertext with key=0 in decrypt mode → `done_o`=2'b10, `block_o`=0.
- Tie and fairness: both requests high from reset for 4 jobs → grant order 0,1,0,1; every captured operand matches its requester.
- Operand stability: change `block0_i` to 0xFF..FF two cycles after the grant → the result still equals the ciphertext of block=0.
- Timeout: stub core holds `core_end_i`=0 with TIMEOUT_CYCLES=16 → `done_o`[k] and `err_o` pulse 18 cycles after the grant, `block_o` unchanged, then the next request is served normally.
- Reset mid-RUN: assert `rst` for 1 cycle during RUN → next cycle IDLE, `core_rst_o`=1, `block_o`=0, no `done_o`; the following tie is granted to requester 0.

Source files
------------

// File: rtl/twofish_arbiter.sv
// twofish_arbiter: round-robin arbiter/sequencer sharing one twofish core
// between two requesters, with per-run timeout.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_i[1:0]         per-requester job request
//   enc_dec_i[1:0]     per-requester direction
//   key0_i/key1_i      per-requester 128-bit key
//   block0_i/block1_i  per-requester 128-bit input block
//   done_o[1:0]        one-cycle completion pulse to the granted requester
//   err_o              pulses with done_o when the run timed out
//   block_o            last completed result, held until next completion
//   busy_o             high whenever the sequencer is not idle
//   core_*_o           operands and reset driven into the twofish core
//   core_block_i       core result
//   core_end_i         core completion flag, high until core reset
module twofish_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_i,
    input  logic [1:0]   enc_dec_i,
    input  logic [127:0] key0_i,
    input  logic [127:0] key1_i,
    input  logic [127:0] block0_i,
    input  logic [127:0] block1_i,
    output logic [1:0]   done_o,
    output logic         err_o,
    output logic [127:0] block_o,
    output logic         busy_o,
    output logic         core_rst_o,
    output logic         core_enc_dec_o,
    output logic [127:0] core_key_o,
    output logic [127:0] core_block_o,
    input  logic [127:0] core_block_i,
    input  logic         core_end_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic          grant;
    logic          last_grant;
    logic [CW-1:0] cnt;
    logic          pick;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        pick = 1'b0;
        unique case (1'b1)
            (req_i == 2'b11): pick = ~last_grant;
            (req_i == 2'b10): pick = 1'b1;
            default:          pick = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            grant          <= 1'b0;
            last_grant     <= 1'b1;
            cnt            <= '0;
            done_o         <= '0;
            err_o          <= 1'b0;
            block_o        <= '0;
            busy_o         <= 1'b0;
            core_rst_o     <= 1'b1;
            core_enc_dec_o <= 1'b0;
            core_key_o     <= '0;
            core_block_o   <= '0;
        end else begin
            done_o <= '0;
            err_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req_i) begin
                        grant          <= pick;
                        last_grant     <= pick;
                        core_enc_dec_o <= enc_dec_i[pick];
                        core_key_o     <= pick ? key1_i : key0_i;
                        core_block_o   <= pick ? block1_i : block0_i;
                        busy_o         <= 1'b1;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    // Core stays in reset one more cycle with stable operands.
                    cnt        <= '0;
                    core_rst_o <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    if (core_end_i) begin
                        block_o       <= core_block_i;
                        done_o[grant] <= 1'b1;
                        err_o         <= 1'b0;
                        core_rst_o    <= 1'b1;
                        state         <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        done_o[grant] <= 1'b1;
                        err_o         <= 1'b1;
                        core_rst_o    <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_twofish_arbiter.sv
// tb_twofish_arbiter: directed bench for twofish_arbiter using a
// behavioural core stub (result = block ^ key ^ K, fixed latency).
module tb_twofish_arbiter;

    localparam logic [127:0] K = 128'h9F589F5CF6122C32B6BFEC2F2AE8C35A;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_i = '0;
    logic [1:0]   enc_dec_i = '0;
    logic [127:0] key0_i = '0;
    logic [127:0] key1_i = '0;
    logic [127:0] block0_i = '0;
    logic [127:0] block1_i = '0;
    logic [1:0]   done_o;
    logic         err_o;
    logic [127:0] block_o;
    logic         busy_o;
    logic         core_rst_o;
    logic         core_enc_dec_o;
    logic [127:0] core_key_o;
    logic [127:0] core_block_o;
    logic [127:0] core_block_i = '0;
    logic         core_end_i = 1'b0;

    int checks = 0;
    int errors = 0;

    logic         hang = 1'b0;
    logic         mod_blk = 1'b0;
    int           scnt = 0;
    logic [127:0] lk;
    logic [127:0] lb;
    logic         le;
    logic         lr1;
    logic         lr2;

    twofish_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .enc_dec_i      (enc_dec_i),
        .key0_i         (key0_i),
        .key1_i         (key1_i),
        .block0_i       (block0_i),
        .block1_i       (block1_i),
        .done_o         (done_o),
        .err_o          (err_o),
        .block_o        (block_o),
        .busy_o         (busy_o),
        .core_rst_o     (core_rst_o),
        .core_enc_dec_o (core_enc_dec_o),
        .core_key_o     (core_key_o),
        .core_block_o   (core_block_o),
        .core_block_i   (core_block_i),
        .core_end_i     (core_end_i)
    );

    always #5 clk = ~clk;

    // Core stub: end rises LAT run-edges after reset release, held until reset.
    always @(posedge clk) begin
        if (core_rst_o) begin
            scnt       <= 0;
            core_end_i <= 1'b0;
        end else if (!hang) begin
            scnt <= scnt + 1;
            if (scnt == LAT - 1) begin
                core_end_i   <= 1'b1;
                core_block_i <= core_block_o ^ core_key_o ^ K;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Waits for a done pulse; n counts negedges, n==1 is the LOAD cycle.
    task automatic wait_done(output logic [1:0] d, output logic e,
                             output int n);
        d = '0;
        e = 1'b0;
        n = 0;
        while (d == 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                lk  = core_key_o;
                lb  = core_block_o;
                le  = core_enc_dec_o;
                lr1 = core_rst_o;
            end
            if (n == 2) begin
                lr2 = core_rst_o;
                if (mod_blk) block0_i = '1;
            end
            d = done_o;
            e = err_o;
        end
    endtask

    logic [1:0]   d;
    logic         e;
    int           n;
    int           g;
    int           seen;
    logic [127:0] prev;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_core_rst", core_rst_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_block", block_o, 0);
        chk("rst_key", core_key_o, 0);
        rst = 1'b0;

        // Single encrypt job, requester 0.
        enc_dec_i = 2'b01;
        req_i = 2'b01;
        wait_done(d, e, n);
        req_i = 2'b00;
        chk("enc_done", d, 2'b01);
        chk("enc_err", e, 0);
        chk("enc_block", block_o, K);
        chk("enc_lat", n, 7);
        chk("enc_rst_load", lr1, 1);
        chk("enc_rst_run", lr2, 0);
        chk("enc_dir", le, 1);
        @(negedge clk);

        // Decrypt round trip, requester 1.
        block1_i = K;
        req_i = 2'b10;
        wait_done(d, e, n);
        req_i = 2'b00;
        chk("dec_done", d, 2'b10);
        chk("dec_block", block_o, 0);
        chk("dec_dir", le, 0);
        chk("dec_in", lb, K);
        @(negedge clk);

        // Tie and fairness from reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        key0_i = 128'h11;
        key1_i = 128'h2200;
        block0_i = 128'h333000;
        block1_i = 128'h44440000;
        req_i = 2'b11;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) @(negedge clk);
            g = j % 2;
            wait_done(d, e, n);
            chk("fair_done", d, g ? 2'b10 : 2'b01);
            chk("fair_key", lk, g ? key1_i : key0_i);
            chk("fair_blk", lb, g ? block1_i : block0_i);
            chk("fair_dir", le, enc_dec_i[g]);
            chk("fair_res", block_o,
                g ? (128'h44440000 ^ 128'h2200 ^ K)
                  : (128'h333000 ^ 128'h11 ^ K));
            chk("fair_lat", n, 7);
        end
        req_i = 2'b00;
        @(negedge clk);

        // Operand change after the grant must not disturb the job.
        key0_i = '0;
        block0_i = '0;
        mod_blk = 1'b1;
        req_i = 2'b01;
        wait_done(d, e, n);
        req_i = 2'b00;
        mod_blk = 1'b0;
        chk("stab_done", d, 2'b01);
        chk("stab_in", lb, 0);
        chk("stab_block", block_o, K);
        @(negedge clk);

        // Timeout with a hung core.
        hang = 1'b1;
        prev = block_o;
        req_i = 2'b10;
        wait_done(d, e, n);
        req_i = 2'b00;
        hang = 1'b0;
        chk("to_done", d, 2'b10);
        chk("to_err", e, 1);
        chk("to_lat", n, 18);
        chk("to_block", block_o, prev);
        @(negedge clk);
        chk("to_err_pulse", err_o, 0);

        // Normal job after timeout.
        key0_i = 128'h5;
        block0_i = 128'hA0;
        req_i = 2'b01;
        wait_done(d, e, n);
        req_i = 2'b00;
        chk("post_done", d, 2'b01);
        chk("post_err", e, 0);
        chk("post_block", block_o, 128'hA5 ^ K);
        @(negedge clk);

        // Reset in the middle of RUN.
        req_i = 2'b01;
        repeat (4) @(negedge clk);
        chk("mid_in_run", core_rst_o, 0);
        rst = 1'b1;
        req_i = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_busy", busy_o, 0);
        chk("mid_core_rst", core_rst_o, 1);
        chk("mid_block", block_o, 0);
        chk("mid_done", done_o, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_o != 2'b00) seen++;
        end
        chk("mid_no_done", seen, 0);
        req_i = 2'b11;
        wait_done(d, e, n);
        req_i = 2'b00;
        chk("mid_tie", d, 2'b01);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
